// File: rtl/alu_rr_if.sv
// Request/response bundle between requesting engines and the shared round-robin ALU.
// The rsp_err member exists only when ALU_ERR_EN is defined.
interface alu_rr_if #(
    parameter int N = 4
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   req;
    logic [4*N-1:0] op_flat;
    logic [8*N-1:0] a_flat;
    logic [8*N-1:0] b_flat;
    logic [N-1:0]   gnt;
    logic           busy;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [7:0]     rsp_data;
    logic           rsp_carry;
`ifdef ALU_ERR_EN
    logic           rsp_err;
`endif

    modport master (
        output req, op_flat, a_flat, b_flat, rsp_ready,
        input  gnt, busy, rsp_valid, rsp_id, rsp_data, rsp_carry
`ifdef ALU_ERR_EN
        , input rsp_err
`endif
    );

    modport slave (
        input  req, op_flat, a_flat, b_flat, rsp_ready,
        output gnt, busy, rsp_valid, rsp_id, rsp_data, rsp_carry
`ifdef ALU_ERR_EN
        , output rsp_err
`endif
    );
endinterface

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one 8-bit, 16-op ALU between N requesters.
// Optional ALU_ERR_EN macro adds rsp_err (divide-by-zero flag).
module alu_rr_scheduler #(
    parameter int N = 4
) (
    input logic   clk,
    input logic   rst_n,
    alu_rr_if.slave bus
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic           pick_vld;
    logic [IDW-1:0] pick_id;
    logic [IDW-1:0] ptr_next;
    logic [3:0]     op_p0;
    logic [7:0]     a_p0;
    logic [7:0]     b_p0;
    logic [IDW-1:0] id_p0;
    logic [8:0]     alu_res;

    // Returns {carry, result}; carry is meaningful only for add/sub.
    function automatic logic [8:0] alu_exec(input logic [3:0] op,
                                            input logic [7:0] a,
                                            input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'(a) * 16'(b);
        case (op)
            4'd0:    alu_exec = {1'b0, a} + {1'b0, b};
            4'd1:    alu_exec = {1'b0, a} - {1'b0, b};
            4'd2:    alu_exec = {1'b0, prod[7:0]};
            4'd3:    alu_exec = (b == 8'd0) ? 9'h0FF : {1'b0, a / b};
            4'd4:    alu_exec = {1'b0, a[6:0], 1'b0};
            4'd5:    alu_exec = {2'b00, a[7:1]};
            4'd6:    alu_exec = {1'b0, a[6:0], a[7]};
            4'd7:    alu_exec = {1'b0, a[0], a[7:1]};
            4'd8:    alu_exec = {1'b0, a & b};
            4'd9:    alu_exec = {1'b0, a | b};
            4'd10:   alu_exec = {1'b0, a ^ b};
            4'd11:   alu_exec = {1'b0, ~(a & b)};
            4'd12:   alu_exec = {1'b0, ~(a ^ b)};
            4'd13:   alu_exec = {1'b0, ~(a | b)};
            4'd14:   alu_exec = (a > b)  ? 9'h0FF : 9'h000;
            default: alu_exec = (a == b) ? 9'h0FF : 9'h000;
        endcase
    endfunction

    // Scan from rr_ptr upward; iterating downward lets the closest requester win.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (bus.req[(int'(rr_ptr) + k) % N]) begin
                pick_vld = 1'b1;
                pick_id  = IDW'((int'(rr_ptr) + k) % N);
            end
        end
    end

    assign ptr_next = (pick_id == IDW'(N - 1)) ? '0 : pick_id + 1'b1;
    assign alu_res  = alu_exec(op_p0, a_p0, b_p0);
    assign bus.busy = (state != IDLE);

    // p0: operand capture of the granted requester
    always_ff @(posedge clk) begin
        if (state == IDLE && pick_vld) begin
            op_p0 <= bus.op_flat[4*pick_id +: 4];
            a_p0  <= bus.a_flat[8*pick_id +: 8];
            b_p0  <= bus.b_flat[8*pick_id +: 8];
            id_p0 <= pick_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            bus.gnt       <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_data  <= 8'd0;
            bus.rsp_carry <= 1'b0;
`ifdef ALU_ERR_EN
            bus.rsp_err   <= 1'b0;
`endif
        end else begin
            bus.gnt <= '0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        bus.gnt <= N'(1) << pick_id;
                        rr_ptr  <= ptr_next;
                        state   <= EXEC;
                    end
                end
                // p1: execute and register the response
                EXEC: begin
                    bus.rsp_data  <= alu_res[7:0];
                    bus.rsp_carry <= alu_res[8];
                    bus.rsp_id    <= id_p0;
                    bus.rsp_valid <= 1'b1;
`ifdef ALU_ERR_EN
                    bus.rsp_err   <= (op_p0 == 4'd3) && (b_p0 == 8'd0);
`endif
                    state         <= RESP;
                end
                // p2: hold response until the consumer takes it
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
